display_scan_ctrl: RTL and testbench

Time-multiplexing scheduler for the calculator's 4-digit seven-segment display.
- Generates the refresh slot sequence (digit select 0..3) from a clock prescaler.
- Inserts an anti-ghosting blank interval at the start of every slot.
- Accepts new 4-digit frames over a valid/ready handshake and applies them only at frame boundaries, so the display never tears.
- Sits between the calculator result/BCD-to-segment logic and the board anode/segment pins.

---
 rtl/disp_pkg.sv | 31 +++
 rtl/scan_prescaler.sv | 33 +++
 rtl/display_scan_ctrl.sv | 118 +++++++++++
 tb/tb_display_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, scan state type and digit helper for the display scanner
//
// Contents:
//   NUM_DIGITS   number of multiplexed digits
//   ZERO_CODE    active-low segment code of the digit '0'
//   BLANK_CODE   active-low segment code with every segment and dp off
//   scan_state_t BLANK (anodes off) / DRIVE (current digit lit)
//   lead_zero()  1 when a digit is a leading zero of the frame (digit 0 never is)

package disp_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] ZERO_CODE  = 8'hC0;
  localparam logic [7:0] BLANK_CODE = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // A digit is a leading zero when it and every more-significant digit show '0'.
  function automatic logic lead_zero(input logic [31:0] frame, input logic [1:0] digit);
    logic z;
    z = (digit != 2'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(digit) && frame[8*k +: 8] != ZERO_CODE) z = 1'b0;
    end
    return z;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - clock prescaler producing the scan tick
//
// Ports:
//   clk_in  system clock
//   rst     synchronous active-high reset (count returns to 0)
//   en      count enable; low holds the count and suppresses tick
//   tick    high for the one cycle the count equals CLK_DIV-1

module scan_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit seven-segment scan scheduler with tear-free frame update
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
//
// Ports:
//   clk_in          system clock
//   rst             synchronous active-high reset
//   en              scan enable; low freezes the scan position and blanks the display
//   upd_valid       new frame offered
//   upd_data[31:0]  frame, byte k = active-low segment code of digit k (digit 3 most significant)
//   upd_ready       pending buffer empty, a frame can be accepted
//   refreshcounter  current slot index 0..3
//   an_n[3:0]       active-low anode enables
//   seg_n[7:0]      active-low segment and dp drive
//   frame_done      one-cycle pulse when slot 3 ends

module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV     = 100000,
  parameter int SLOT_TICKS  = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic        upd_valid,
  input  logic [31:0] upd_data,
  output logic        upd_ready,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  an_n,
  output logic [7:0]  seg_n,
  output logic        frame_done
);

  localparam int            TW     = $clog2(SLOT_TICKS);
  localparam logic [TW-1:0] LAST_T = TW'(SLOT_TICKS - 1);
  localparam logic [TW-1:0] BT     = TW'(BLANK_TICKS);

  logic          tick;
  logic [TW-1:0] tick_cnt, tick_cnt_nxt;
  logic [1:0]    rc_nxt;
  scan_state_t   state, state_nxt;
  logic [31:0]   active, active_nxt, pending;
  logic          pend_full;
  logic          slot_end, boundary, show;
  logic [3:0]    an_nxt;
  logic [7:0]    seg_nxt;

  scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .tick   (tick)
  );

  assign upd_ready = !pend_full;

  always_comb begin
    slot_end     = tick && (tick_cnt == LAST_T);
    boundary     = slot_end && (refreshcounter == 2'd3);
    tick_cnt_nxt = tick_cnt;
    rc_nxt       = refreshcounter;
    state_nxt    = state;

    if (tick) tick_cnt_nxt = slot_end ? '0 : tick_cnt + 1'b1;
    if (slot_end) rc_nxt = refreshcounter + 2'd1;

    case (state)
      // With BLANK_TICKS=0 the slot-end tick already lands on count BT, so DRIVE follows directly.
      BLANK:   if (tick && tick_cnt_nxt == BT) state_nxt = DRIVE;
      DRIVE:   if (slot_end && BLANK_TICKS != 0) state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase

    active_nxt = (boundary && pend_full) ? pending : active;

    // Outputs are computed from next-cycle values so the registered pins follow the causing tick by one cycle.
    show = en && (state_nxt == DRIVE);
`ifdef LEADING_ZERO_BLANK_EN
    show = show && !lead_zero(active_nxt, rc_nxt);
`else
    show = show;
`endif
    an_nxt  = show ? ~(4'b0001 << rc_nxt) : 4'hF;
    seg_nxt = show ? active_nxt[{rc_nxt, 3'b000} +: 8] : BLANK_CODE;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_cnt       <= '0;
      refreshcounter <= 2'd0;
      state          <= BLANK;
      active         <= 32'hFFFF_FFFF;
      pending        <= 32'hFFFF_FFFF;
      pend_full      <= 1'b0;
      an_n           <= 4'hF;
      seg_n          <= BLANK_CODE;
      frame_done     <= 1'b0;
    end else begin
      tick_cnt       <= tick_cnt_nxt;
      refreshcounter <= rc_nxt;
      state          <= state_nxt;
      active         <= active_nxt;
      an_n           <= an_nxt;
      seg_n          <= seg_nxt;
      frame_done     <= boundary;
      // A boundary only drains a full buffer, and a capture only fills an empty one, so they never collide.
      if (boundary && pend_full) begin
        pend_full <= 1'b0;
      end else if (upd_valid && !pend_full) begin
        pending   <= upd_data;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - self-checking bench for display_scan_ctrl

module tb_display_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int ST      = 4;
  localparam int BT      = 1;
  localparam int SLOT    = CLK_DIV * ST;
  localparam int FRAME   = SLOT * 4;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1, en = 1'b0, upd_valid = 1'b0;
  logic [31:0] upd_data = 32'h0;
  logic        upd_ready, frame_done;
  logic [1:0]  refreshcounter;
  logic [3:0]  an_n;
  logic [7:0]  seg_n;

  always #5 clk_in = ~clk_in;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .SLOT_TICKS(ST), .BLANK_TICKS(BT)) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .en             (en),
    .upd_valid      (upd_valid),
    .upd_data       (upd_data),
    .upd_ready      (upd_ready),
    .refreshcounter (refreshcounter),
    .an_n           (an_n),
    .seg_n          (seg_n),
    .frame_done     (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position is just the number of enabled cycles since reset.
  int          p;
  logic [31:0] m_active, m_pend;
  bit          m_full;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_done;
  logic [1:0]  e_rc;

  function automatic bit m_suppress(input logic [31:0] f, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    bit z;
    z = (k != 0);
    for (int j = k; j < 4; j++) if (f[8*j +: 8] != 8'hC0) z = 0;
    return z;
`else
    return (f[7:0] != f[7:0]) && (k < 0);
`endif
  endfunction

  function automatic logic [15:0] exp_vec();
    return {e_an, e_seg, e_done, ~m_full, e_rc};
  endfunction

  function automatic logic [15:0] obs_vec();
    return {an_n, seg_n, frame_done, upd_ready, refreshcounter};
  endfunction

  task automatic step();
    bit bnd, cap, show;
    int t;
    @(posedge clk_in);
    if (rst) begin
      p = 0; m_active = 32'hFFFF_FFFF; m_full = 0; e_done = 0;
    end else begin
      bnd = 0;
      cap = upd_valid && !m_full;
      if (en) begin
        if (p % CLK_DIV == CLK_DIV - 1 && ((p + 1) / CLK_DIV) % (ST * 4) == 0) bnd = 1;
        p++;
      end
      if (bnd && m_full) begin m_active = m_pend; m_full = 0; end
      if (cap) begin m_pend = upd_data; m_full = 1; end
      e_done = bnd;
    end
    t    = p / CLK_DIV;
    e_rc = 2'((t / ST) % 4);
    show = !rst && en && (t % ST) >= BT && !m_suppress(m_active, int'(e_rc));
    e_an  = show ? ~(4'b0001 << e_rc) : 4'hF;
    e_seg = show ? m_active[8*e_rc +: 8] : 8'hFF;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; upd_valid = 0;
    step(); step();
    n_cmp++;
    if (obs_vec() !== {4'hF, 8'hFF, 1'b0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset: got %h want %h", obs_vec(), {4'hF, 8'hFF, 1'b0, 1'b1, 2'd0});
    end
    rst = 0;
  endtask

  task automatic test_scan();
    int dones = 0;
    en = 1;
    repeat (3 * FRAME) begin
      step();
      if (frame_done === 1'b1) dones++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL scan: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
    n_cmp++;
    if (dones != 3) begin n_bad++; $display("FAIL scan_done_count: got %0d want 3", dones); end
  endtask

  task automatic test_update();
    int i;
    for (i = 0; i < 2 * FRAME && !(e_rc == 2'd1 && p % SLOT == 8); i++) step();
    upd_valid = 1; upd_data = 32'h99B0A4F9;
    step();
    n_cmp++;
    if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL upd_ready_drop: got %b want 0", upd_ready); end
    // Second frame offered while full; held until accepted.
    upd_data = 32'h8092_A4C0;
    for (i = 0; i < 3 * FRAME; i++) begin
      step();
      if (upd_ready === 1'b1 && !m_full) upd_valid = upd_valid;
      if (m_full && m_pend == 32'h8092_A4C0) upd_valid = 0;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL update: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
    upd_valid = 0;
    n_cmp++;
    if (m_active !== 32'h8092_A4C0 || seg_n === 8'hXX) begin
      n_bad++; $display("FAIL update_applied: got %h want %h", m_active, 32'h8092_A4C0);
    end
  endtask

  task automatic test_boundary_capture();
    int i;
    for (i = 0; i < 3 * FRAME && !(!m_full && p % FRAME == FRAME - 1); i++) step();
    n_cmp++;
    if (i >= 3 * FRAME) begin n_bad++; $display("FAIL boundary_wait: got timeout want boundary"); end
    upd_valid = 1; upd_data = $urandom;
    step();
    upd_valid = 0;
    n_cmp++;
    if (frame_done !== 1'b1 || upd_ready !== 1'b0) begin
      n_bad++; $display("FAIL boundary_capture: got done=%b rdy=%b want done=1 rdy=0", frame_done, upd_ready);
    end
    repeat (2 * FRAME) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL boundary: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
  endtask

  task automatic test_enable_pause();
    int i;
    for (i = 0; i < 2 * FRAME && !(e_rc == 2'd2 && e_an != 4'hF); i++) step();
    en = 0;
    step();
    n_cmp++;
    if (an_n !== 4'hF || seg_n !== 8'hFF) begin
      n_bad++; $display("FAIL pause_blank: got an_n=%h seg_n=%h want F FF", an_n, seg_n);
    end
    repeat (19) step();
    en = 1;
    repeat (FRAME + SLOT) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL pause: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
  endtask

  task automatic test_leading_zero();
    int i;
    upd_valid = 1; upd_data = 32'hC0C0_F9C0;
    for (i = 0; i < 3 * FRAME; i++) begin
      step();
      if (m_full && m_pend == 32'hC0C0_F9C0) upd_valid = 0;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL lead_zero: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
    upd_valid = 0;
  endtask

  task automatic test_random();
    logic [31:0] d;
    repeat (3000) begin
      en = ($urandom_range(0, 9) != 0);
      if (!upd_valid || !m_full) begin
        upd_valid = ($urandom_range(0, 7) == 0);
        d = $urandom;
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 1) d[8*k +: 8] = 8'hC0;
        upd_data = d;
      end
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
    en = 1; upd_valid = 0;
  endtask

  task automatic test_reset_midframe();
    repeat (FRAME / 2 + 5) step();
    rst = 1;
    step();
    n_cmp++;
    if (obs_vec() !== {4'hF, 8'hFF, 1'b0, 1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got %h want %h", obs_vec(), {4'hF, 8'hFF, 1'b0, 1'b1, 2'd0});
    end
    rst = 0;
    repeat (FRAME) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL after_reset: got %h want %h at p=%0d", obs_vec(), exp_vec(), p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_update();
    test_boundary_capture();
    test_enable_pause();
    test_leading_zero();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
